// File: rtl/inst_enc.sv
// RV32I instruction encoder: field bundle in, 32-bit instruction word out.
// Results are held in a 2-entry in-order FIFO with delivery and error counters.
module inst_enc (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_cls,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_err,
  output logic [15:0] enc_cnt,
  output logic [15:0] err_cnt
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0] raw;
  logic        bad;
  logic [32:0] enc;
  logic        sx11, sx12, sx20;

  assign sx11 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign sx12 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
  assign sx20 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

  always_comb begin
    raw = 32'h0;
    bad = 1'b0;
    case (in_cls)
      4'd0: begin
        raw = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
        bad = ~sx11;
      end
      4'd1: begin
        raw = {in_imm[11:5], in_rs2, in_rs1, in_funct3,
               in_imm[4:0], 7'b0100011};
        bad = ~sx11;
      end
      4'd2: begin
        raw = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
               in_imm[4:1], in_imm[11], 7'b1100011};
        bad = ~sx12 | in_imm[0];
      end
      4'd3: begin
        raw = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b1100111};
        bad = ~sx11;
      end
      4'd4: begin
        raw = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
               in_rd, 7'b1101111};
        bad = ~sx20 | in_imm[0];
      end
      4'd5: begin
        raw = {in_imm[31:12], in_rd, 7'b0110111};
        bad = |in_imm[11:0];
      end
      4'd6: begin
        raw = {in_imm[31:12], in_rd, 7'b0010111};
        bad = |in_imm[11:0];
      end
      4'd7: begin
        // Shifts carry funct7 in the upper immediate bits
        if (in_funct3 == 3'b001 || in_funct3 == 3'b101) begin
          raw = {in_funct7, in_imm[4:0], in_rs1, in_funct3,
                 in_rd, 7'b0010011};
          bad = |in_imm[31:5];
        end else begin
          raw = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
          bad = ~sx11;
        end
      end
      4'd8: begin
        raw = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
      end
      4'd9: begin
        raw = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b1110011};
        bad = ~sx11;
      end
      default: bad = 1'b1;
    endcase
    enc = bad ? {1'b1, NOP} : {1'b0, raw};
  end

  logic [32:0] mem_q [2];
  logic [32:0] mem_d [2];
  logic        wp_q, wp_d, rp_q, rp_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] enc_cnt_q, enc_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic        push, pop;

  assign in_ready  = (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_inst = out_valid ? mem_q[rp_q][31:0] : 32'h0;
  assign out_err  = out_valid & mem_q[rp_q][32];
  assign enc_cnt  = enc_cnt_q;
  assign err_cnt  = err_cnt_q;

  always_comb begin
    mem_d     = mem_q;
    wp_d      = wp_q;
    rp_d      = rp_q;
    cnt_d     = cnt_q;
    enc_cnt_d = enc_cnt_q;
    err_cnt_d = err_cnt_q;
    if (push) begin
      mem_d[wp_q] = enc;
      wp_d        = ~wp_q;
    end
    if (pop) begin
      rp_d      = ~rp_q;
      enc_cnt_d = enc_cnt_q + 16'd1;
      if (mem_q[rp_q][32]) err_cnt_d = err_cnt_q + 16'd1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0]  <= '0;
      mem_q[1]  <= '0;
      wp_q      <= 1'b0;
      rp_q      <= 1'b0;
      cnt_q     <= 2'd0;
      enc_cnt_q <= 16'd0;
      err_cnt_q <= 16'd0;
    end else begin
      mem_q     <= mem_d;
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      cnt_q     <= cnt_d;
      enc_cnt_q <= enc_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_inst_enc.sv
// Self-checking bench for inst_enc: directed vectors, backpressure,
// mid-run reset and a randomized run against an arithmetic reference model.
module tb_inst_enc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_cls;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_err;
  logic [15:0] enc_cnt, err_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0]  cls;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
  } req_t;

  inst_enc dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_cls(in_cls), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_err(out_err),
    .enc_cnt(enc_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference encoder: range checks on the signed value, fields by arithmetic
  function automatic logic [32:0] ref_enc(input req_t r);
    logic [6:0]  opc [10];
    logic [31:0] w, imm, rs1s, rs2s, rds, f3s, f7s;
    longint      si;
    bit          ok;
    opc = '{7'h03, 7'h23, 7'h63, 7'h67, 7'h6F,
            7'h37, 7'h17, 7'h13, 7'h33, 7'h73};
    imm  = r.imm;
    si   = longint'($signed(r.imm));
    rs1s = 32'(r.rs1) << 15;
    rs2s = 32'(r.rs2) << 20;
    rds  = 32'(r.rd) << 7;
    f3s  = 32'(r.f3) << 12;
    f7s  = 32'(r.f7) << 25;
    ok   = 1'b1;
    w    = 32'h0;
    if (r.cls > 9) begin
      ok = 1'b0;
    end else begin
      w = 32'(opc[r.cls]);
      case (r.cls)
        0, 3, 9: begin
          ok = si >= -2048 && si <= 2047;
          w |= ((imm & 32'hFFF) << 20) | rs1s | f3s | rds;
        end
        1: begin
          ok = si >= -2048 && si <= 2047;
          w |= (((imm >> 5) & 32'h7F) << 25) | rs2s | rs1s | f3s
               | ((imm & 32'h1F) << 7);
        end
        2: begin
          ok = si >= -4096 && si <= 4095 && (si % 2 == 0);
          w |= (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25)
               | rs2s | rs1s | f3s | (((imm >> 1) & 32'hF) << 8)
               | (((imm >> 11) & 1) << 7);
        end
        4: begin
          ok = si >= -(64'sd1 << 20) && si < (64'sd1 << 20) && (si % 2 == 0);
          w |= (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
               | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12)
               | rds;
        end
        5, 6: begin
          ok = (imm % 4096) == 0;
          w |= imm | rds;
        end
        7: begin
          if (r.f3 == 1 || r.f3 == 5) begin
            ok = imm < 32;
            w |= f7s | (imm << 20) | rs1s | f3s | rds;
          end else begin
            ok = si >= -2048 && si <= 2047;
            w |= ((imm & 32'hFFF) << 20) | rs1s | f3s | rds;
          end
        end
        default: w |= f7s | rs2s | rs1s | f3s | rds;
      endcase
    end
    return ok ? {1'b0, w} : {1'b1, 32'h13};
  endfunction

  function automatic req_t mk(input logic [3:0] c, input logic [2:0] f3,
                              input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [31:0] imm);
    req_t r;
    r.cls = c; r.f3 = f3; r.f7 = 7'h0;
    r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.imm = imm;
    return r;
  endfunction

  task automatic drive(input req_t r, input logic v);
    in_valid  = v;
    in_cls    = r.cls;
    in_funct3 = r.f3;
    in_funct7 = r.f7;
    in_rs1    = r.rs1;
    in_rs2    = r.rs2;
    in_rd     = r.rd;
    in_imm    = r.imm;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req_t z;
    z = mk(4'd0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    drive(z, 1'b0);
    out_ready = 1'b0;
    apply_reset();
    checks++;
    if (out_valid !== 1'b0 || out_inst !== 32'h0 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: valid=%b inst=%h err=%b want 0/0/0",
               out_valid, out_inst, out_err);
    end
    checks++;
    if (enc_cnt !== 16'd0 || err_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_cnt: enc=%0d err=%0d want 0/0", enc_cnt, err_cnt);
    end
    step();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_vectors();
    req_t        v [5];
    logic [31:0] want [5];
    logic        werr [5];
    v[0] = mk(4'd7, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    v[1] = mk(4'd1, 3'd2, 5'd0, 5'd3, 5'd2, 32'hFFFF_FFFC);
    v[2] = mk(4'd4, 3'd0, 5'd1, 5'd0, 5'd0, 32'h800);
    v[3] = mk(4'd5, 3'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
    v[4] = mk(4'd2, 3'd0, 5'd0, 5'd1, 5'd2, 32'h0000_0FFE);
    want = '{32'h0050_0093, 32'hFE21_AE23, 32'h0010_00EF,
             32'h1234_52B7, 32'h7E20_8FE3};
    werr = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      out_ready = 1'b0;
      drive(v[i], 1'b1);
      step();
      drive(v[i], 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out_inst !== want[i] ||
          out_err !== werr[i]) begin
        errors++;
        $display("FAIL vec%0d: valid=%b inst=%h err=%b want 1/%h/%b",
                 i, out_valid, out_inst, out_err, want[i], werr[i]);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || enc_cnt !== 16'(i + 1)) begin
        errors++;
        $display("FAIL vec%0d_pop: valid=%b enc=%0d want 0/%0d",
                 i, out_valid, enc_cnt, i + 1);
      end
    end
  endtask

  task automatic test_errors();
    req_t a, b;
    a = mk(4'd2, 3'd0, 5'd0, 5'd1, 5'd2, 32'd3);
    b = mk(4'd12, 3'd0, 5'd1, 5'd1, 5'd1, 32'd0);
    apply_reset();
    out_ready = 1'b0;
    drive(a, 1'b1);
    step();
    drive(b, 1'b1);
    step();
    drive(b, 1'b0);
    checks++;
    if (out_inst !== 32'h13 || out_err !== 1'b1) begin
      errors++;
      $display("FAIL err_beq: inst=%h err=%b want 00000013/1",
               out_inst, out_err);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_inst !== 32'h13 || out_err !== 1'b1) begin
      errors++;
      $display("FAIL err_cls: valid=%b inst=%h err=%b want 1/00000013/1",
               out_valid, out_inst, out_err);
    end
    step();
    out_ready = 1'b0;
    checks++;
    if (err_cnt !== 16'd2 || enc_cnt !== 16'd2) begin
      errors++;
      $display("FAIL err_cnt: err=%0d enc=%0d want 2/2", err_cnt, enc_cnt);
    end
  endtask

  task automatic test_back_to_back();
    req_t        r [3];
    logic [31:0] got [$];
    int          idx;
    bit          wp, wq;
    logic [31:0] head;
    for (int i = 0; i < 3; i++)
      r[i] = mk(4'd7, 3'd0, 5'(i + 1), 5'd0, 5'd0, 32'(i + 10));
    apply_reset();
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      drive(r[idx], 1'b1);
      wp = in_ready;
      step();
      if (wp) idx++;
      if (idx > 2) idx = 2;
    end
    checks++;
    if (in_ready !== 1'b0 || idx !== 2) begin
      errors++;
      $display("FAIL full_hold: in_ready=%b accepted=%0d want 0/2",
               in_ready, idx);
    end
    checks++;
    if (out_inst !== ref_enc(r[0])[31:0]) begin
      errors++;
      $display("FAIL full_head: inst=%h want %h", out_inst,
               ref_enc(r[0])[31:0]);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 20 && got.size() < 3; c++) begin
      if (idx < 3) drive(r[idx], 1'b1);
      else drive(r[2], 1'b0);
      wp   = in_valid && in_ready;
      wq   = out_valid;
      head = out_inst;
      step();
      if (wp) idx++;
      if (wq) got.push_back(head);
    end
    drive(r[2], 1'b0);
    out_ready = 1'b0;
    checks++;
    if (got.size() != 3) begin
      errors++;
      $display("FAIL b2b_count: got=%0d want 3", got.size());
    end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== ref_enc(r[i])[31:0]) begin
        errors++;
        $display("FAIL b2b_order%0d: inst=%h want %h", i, got[i],
                 ref_enc(r[i])[31:0]);
      end
    end
    checks++;
    if (enc_cnt !== 16'd3) begin
      errors++;
      $display("FAIL b2b_enc: enc=%0d want 3", enc_cnt);
    end
  endtask

  task automatic test_reset_mid();
    req_t a, b;
    a = mk(4'd8, 3'd0, 5'd7, 5'd8, 5'd9, 32'd0);
    b = mk(4'd7, 3'd0, 5'd4, 5'd0, 5'd0, 32'd77);
    apply_reset();
    out_ready = 1'b0;
    drive(a, 1'b1);
    step();
    step();
    out_ready = 1'b1;
    step();
    drive(a, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(a, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || enc_cnt !== 16'd0 || err_cnt !== 16'd0) begin
      errors++;
      $display("FAIL rstmid: valid=%b enc=%0d err=%0d want 0/0/0",
               out_valid, enc_cnt, err_cnt);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_ready: in_ready=%b want 1", in_ready);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_stale: valid=%b inst=%h want 0",
               out_valid, out_inst);
    end
    drive(b, 1'b1);
    step();
    drive(b, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_inst !== ref_enc(b)[31:0]) begin
      errors++;
      $display("FAIL rstmid_new: valid=%b inst=%h want 1/%h",
               out_valid, out_inst, ref_enc(b)[31:0]);
    end
    step();
    out_ready = 1'b0;
  endtask

  function automatic req_t rnd_req();
    req_t r;
    r.cls = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                        : 4'($urandom_range(0, 9));
    r.f3  = 3'($urandom);
    r.f7  = 7'($urandom);
    r.rs1 = 5'($urandom);
    r.rs2 = 5'($urandom);
    r.rd  = 5'($urandom);
    case ($urandom_range(0, 4))
      0: r.imm = $urandom;
      1: r.imm = 32'($urandom_range(0, 4095)) - 32'd2048;
      2: r.imm = (32'($urandom_range(0, 8191)) - 32'd4096) & ~32'd1;
      3: r.imm = $urandom & 32'hFFFF_F000;
      default: r.imm = 32'($urandom_range(0, 40));
    endcase
    if ($urandom_range(0, 3) == 0)
      r.imm = 32'($urandom_range(0, 32'h1F_FFFF)) - 32'h10_0000;
    return r;
  endfunction

  task automatic test_random();
    logic [32:0] q [$];
    logic [15:0] e_enc, e_err;
    req_t        r;
    bit          p, o;
    apply_reset();
    e_enc = 16'd0;
    e_err = 16'd0;
    for (int c = 0; c < 2000; c++) begin
      r = rnd_req();
      drive(r, 1'($urandom_range(0, 3) != 0));
      out_ready = 1'($urandom_range(0, 2) != 0);
      p = in_valid && q.size() < 2;
      o = out_ready && q.size() > 0;
      step();
      if (o) begin
        e_enc++;
        if (q[0][32]) e_err++;
        void'(q.pop_front());
      end
      if (p) q.push_back(ref_enc(r));
      checks++;
      if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin
        errors++;
        $display("FAIL rnd_flow c%0d: valid=%b ready=%b occ=%0d",
                 c, out_valid, in_ready, q.size());
      end
      if (q.size() > 0) begin
        checks++;
        if ({out_err, out_inst} !== q[0]) begin
          errors++;
          $display("FAIL rnd_data c%0d: err=%b inst=%h want %b/%h",
                   c, out_err, out_inst, q[0][32], q[0][31:0]);
        end
      end
      checks++;
      if (enc_cnt !== e_enc || err_cnt !== e_err) begin
        errors++;
        $display("FAIL rnd_cnt c%0d: enc=%0d err=%0d want %0d/%0d",
                 c, enc_cnt, err_cnt, e_enc, e_err);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_vectors();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_enc.md
INST_ENC -- requirements
Module: inst_enc

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst  in  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 SHALL have ports: in_valid  in  1  request present.
REQ-004 SHALL have ports: in_ready  out  1  request accepted when in_valid & in_ready at edge.
REQ-005 SHALL have ports: in_cls  in  4  format class: 0 LOAD, 1 STORE, 2 BRANCH, 3 JALR, 4 JAL, 5 LUI, 6 AUIPC, 7 OP_IMM, 8 OP, 9 SYSTEM; 10-15 invalid.
REQ-006 SHALL have ports: in_funct3  in  3; in_funct7  in  7; in_rs1, in_rs2, in_rd  in  5 each.
REQ-007 SHALL have ports: in_imm  in  32  full sign-extended immediate value, byte offset for B/J, shifted value for U.
REQ-008 SHALL have ports: out_valid  out  1; out_ready  in  1; out_inst  out  32  RV32I word; out_err  out  1  encoding error for this word.
REQ-009 SHALL have ports: enc_cnt  out  16  words delivered; err_cnt  out  16  erroneous words delivered.

Function
REQ-010 SHALL set inst[6:0] = {cls opcode, 2'b11}, cls opcodes 5'b00000, 01000, 11000, 11001, 11011, 01101, 00101, 00100, 01100, 11100 in class order.
REQ-011 SHALL encode I-type (LOAD, JALR, OP_IMM non-shift, SYSTEM) as {imm[11:0], rs1, funct3, rd, opc}; err if imm[31:11] not all equal.
REQ-012 SHALL encode OP_IMM with funct3 001/101 as {funct7, imm[4:0], rs1, funct3, rd, opc}; err if imm[31:5] != 0.
REQ-013 SHALL encode S as {imm[11:5], rs2, rs1, funct3, imm[4:0], opc}; err if imm[31:11] not all equal.
REQ-014 SHALL encode B as {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opc}; err if imm[31:12] not all equal or imm[0] = 1.
REQ-015 SHALL encode U (LUI, AUIPC) as {imm[31:12], rd, opc}; err if imm[11:0] != 0.
REQ-016 SHALL encode J as {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc}; err if imm[31:20] not all equal or imm[0] = 1.
REQ-017 SHALL encode OP as {funct7, rs2, rs1, funct3, rd, opc}; never err.
REQ-018 SHALL err on invalid in_cls.
REQ-019 SHALL substitute out_inst = 32'h0000_0013 (NOP) with out_err = 1 for any erroneous request.
REQ-020 SHALL buffer results in a 2-entry FIFO, in order; in_ready = (occupancy < 2), combinational on occupancy only, not on out_ready.
REQ-021 SHALL have latency 1: request accepted at edge N is visible on out_* after edge N; no combinational in_* -> out_* path.
REQ-022 SHALL present the head entry while out_valid = 1; out_* stable until out_valid & out_ready at an edge pops it.
REQ-023 SHALL apply a simultaneous push and pop in the same edge, leaving occupancy unchanged, with order preserved.
REQ-024 SHALL, when occupancy = 2, ignore in_valid (in_ready = 0) even if out_ready = 1 that cycle.
REQ-025 SHALL ignore out_ready while out_valid = 0.
REQ-026 SHALL increment enc_cnt on each pop, and also increment err_cnt when the popped out_err = 1; both wrap 16'hFFFF -> 0.

Reset
REQ-027 SHALL, while rst = 1 at an edge, empty the FIFO and clear enc_cnt and err_cnt to 0; out_valid = 0, out_inst = 0, out_err = 0 after that edge.
REQ-028 SHALL discard buffered entries on reset mid-operation, and SHALL ignore any in_valid/out_ready in a reset cycle.
REQ-029 SHALL drive in_ready = 1 from the first edge after rst deasserts.

Verification
REQ-030 SHALL be checked with: ADDI, cls 7, f3 0, rd 1, rs1 0, imm 5 -> out_inst 0x00500093, out_err 0, one cycle after accept.
REQ-031 SHALL be checked with: SW, cls 1, f3 2, rs1 3, rs2 2, imm 0xFFFFFFFC -> 0xFE21AE23.
REQ-032 SHALL be checked with: JAL rd 1, imm 0x800 -> 0x001000EF; LUI rd 5, imm 0x12345000 -> 0x123452B7.
REQ-033 SHALL be checked with: BEQ imm 3, and separately cls 12 -> each 0x00000013 with out_err 1; err_cnt 2 after both pop.
REQ-034 SHALL be checked with: out_ready 0, push 3 back-to-back -> in_ready 0 after 2 accepts, third held; then out_ready 1 -> 3 words in order, enc_cnt 3.
REQ-035 SHALL be checked with: FIFO holding 2 entries, rst pulsed 1 cycle -> out_valid 0, counters 0, in_ready 1 next cycle, old entries never appear.
